// File: rtl/sprite_cmd_queue.sv
// ---------------------------------------------------------------------------
// sprite_cmd_queue
//
// Buffers sprite draw commands from a producer and issues them one at a time
// to a downstream sprite drawer using a ready/draw handshake.
//
// Handshake with the drawer:
//   IDLE    : drawer ready and a command is queued -> pop, present it, draw=1
//   ISSUE   : hold draw=1 until the drawer drops ready (it has taken the job)
//             or until ACK_TIMEOUT cycles pass with ready still high
//   RELEASE : draw=0, wait for the drawer to raise ready again (job complete)
//
// Commands whose sprite would not fit on the display are discarded at push
// time and counted.
//
// Ports:
//   clock, reset        clock; asynchronous active-high reset
//   cmdValid/cmdReady   producer handshake (cmdReady = queue not full)
//   cmdX/cmdY/cmdMifId  command payload (origin and sprite id)
//   drawerReady         ready output of the downstream drawer
//   draw                draw request to the drawer
//   xOrigin/yOrigin/
//   mifId               payload of the command currently/last issued
//   busy                queue non-empty or a command in flight
//   level               number of stored entries
//   rejected            one-cycle pulse after a command was discarded
//   rejectCount         saturating count of discarded commands
//   timeoutErr          sticky drawer handshake timeout flag
//   clearErr            clears timeoutErr and rejectCount
// ---------------------------------------------------------------------------
module sprite_cmd_queue #(
    parameter int DEPTH       = 8,
    parameter int SPRITE_W    = 8,
    parameter int SPRITE_H    = 8,
    parameter int LCD_WIDTH   = 240,
    parameter int LCD_HEIGHT  = 320,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmdValid,
    output logic                       cmdReady,
    input  logic [7:0]                 cmdX,
    input  logic [8:0]                 cmdY,
    input  logic [7:0]                 cmdMifId,
    input  logic                       drawerReady,
    output logic                       draw,
    output logic [7:0]                 xOrigin,
    output logic [8:0]                 yOrigin,
    output logic [7:0]                 mifId,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       rejected,
    output logic [7:0]                 rejectCount,
    output logic                       timeoutErr,
    input  logic                       clearErr
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    // Largest origin that still keeps the whole sprite on screen.
    localparam logic [7:0]  X_MAX   = 8'(LCD_WIDTH - SPRITE_W);
    localparam logic [8:0]  Y_MAX   = 9'(LCD_HEIGHT - SPRITE_H);
    localparam logic [AW:0] LVL_MAX = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

    typedef struct packed {
        logic [7:0] x;
        logic [8:0] y;
        logic [7:0] id;
    } sprite_cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    sprite_cmd_t   mem [DEPTH];
    sprite_cmd_t   cmd_in;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tcnt;

    logic full;
    logic push;
    logic push_bad;
    logic push_ok;
    logic pop;
    logic timeout_hit;

    assign cmd_in   = '{x: cmdX, y: cmdY, id: cmdMifId};
    assign full     = (level == LVL_MAX);
    assign cmdReady = !full;
    assign busy     = (state != IDLE) || (level != '0);

    assign push     = cmdValid && cmdReady;
    assign push_bad = push && ((cmdX > X_MAX) || (cmdY > Y_MAX));
    assign push_ok  = push && !push_bad;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if ((level != '0) && drawerReady) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // A ready drop on the final cycle still counts as an accept.
                if (!drawerReady) begin
                    state_nxt = RELEASE;
                end else if (tcnt == T_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            RELEASE: begin
                if (drawerReady) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            draw  <= 1'b0;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            // Registered so draw is a clean flop output toward the drawer.
            draw  <= (state_nxt == ISSUE);
            if (pop)                tcnt <= '0;
            else if (state == ISSUE) tcnt <= tcnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------- FIFO
    // Storage needs no reset: nothing is read unless level says it was written.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= cmd_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            xOrigin <= '0;
            yOrigin <= '0;
            mifId   <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                xOrigin <= mem[rd_ptr].x;
                yOrigin <= mem[rd_ptr].y;
                mifId   <= mem[rd_ptr].id;
            end
            unique case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // -------------------------------------------------------------- status
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rejected    <= 1'b0;
            rejectCount <= '0;
            timeoutErr  <= 1'b0;
        end else begin
            rejected <= push_bad;
            // A rejection in the clear cycle wins and keeps counting.
            if (push_bad) begin
                if (rejectCount != 8'hFF) rejectCount <= rejectCount + 1'b1;
            end else if (clearErr) begin
                rejectCount <= '0;
            end
            if (timeout_hit)   timeoutErr <= 1'b1;
            else if (clearErr) timeoutErr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_cmd_queue.sv
`timescale 1ns/1ps
module tb_sprite_cmd_queue;
    localparam int DEPTH       = 8;
    localparam int ACK_TIMEOUT = 1023;
    localparam int X_MAX       = 232;
    localparam int Y_MAX       = 312;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmdValid = 1'b0;
    logic       cmdReady;
    logic [7:0] cmdX = '0;
    logic [8:0] cmdY = '0;
    logic [7:0] cmdMifId = '0;
    logic       drawerReady = 1'b1;
    logic       draw;
    logic [7:0] xOrigin;
    logic [8:0] yOrigin;
    logic [7:0] mifId;
    logic       busy;
    logic [3:0] level;
    logic       rejected;
    logic [7:0] rejectCount;
    logic       timeoutErr;
    logic       clearErr = 1'b0;

    sprite_cmd_queue #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdX(cmdX), .cmdY(cmdY), .cmdMifId(cmdMifId),
        .drawerReady(drawerReady), .draw(draw),
        .xOrigin(xOrigin), .yOrigin(yOrigin), .mifId(mifId),
        .busy(busy), .level(level),
        .rejected(rejected), .rejectCount(rejectCount),
        .timeoutErr(timeoutErr), .clearErr(clearErr)
    );

    always #5 clock = ~clock;

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------- behavioural model
    // Queue of accepted commands plus a description of the job in flight:
    // whether one exists, whether the drawer has taken it, and when it went out.
    typedef struct {
        int x;
        int y;
        int id;
    } cmd_t;

    cmd_t mq[$];
    bit   m_inflight = 0;
    bit   m_taken    = 0;
    int   m_issue_cyc = 0;
    int   m_cyc = 0;
    int   m_x = 0, m_y = 0, m_id = 0;
    bit   m_rej = 0;
    int   m_rcnt = 0;
    bit   m_terr = 0;

    task automatic model_reset();
        mq.delete();
        m_inflight = 0;
        m_taken    = 0;
        m_x = 0; m_y = 0; m_id = 0;
        m_rej  = 0;
        m_rcnt = 0;
        m_terr = 0;
    endtask

    task automatic model_step();
        bit   acc, bad, tmo;
        cmd_t c;
        if (reset) begin
            model_reset();
        end else begin
            acc = cmdValid && (mq.size() < DEPTH);
            bad = acc && ((int'(cmdX) > X_MAX) || (int'(cmdY) > Y_MAX));
            tmo = 0;
            if (m_inflight && !m_taken) begin
                if (!drawerReady) m_taken = 1;
                else if (m_cyc - m_issue_cyc == ACK_TIMEOUT) begin
                    m_inflight = 0;
                    tmo = 1;
                end
            end else if (m_inflight) begin
                if (drawerReady) m_inflight = 0;
            end else if (mq.size() > 0 && drawerReady) begin
                c = mq.pop_front();
                m_x = c.x; m_y = c.y; m_id = c.id;
                m_inflight  = 1;
                m_taken     = 0;
                m_issue_cyc = m_cyc;
            end
            if (acc && !bad) begin
                c.x = int'(cmdX); c.y = int'(cmdY); c.id = int'(cmdMifId);
                mq.push_back(c);
            end
            m_rej = bad;
            if (bad) begin
                if (m_rcnt < 255) m_rcnt++;
            end else if (clearErr) m_rcnt = 0;
            if (tmo) m_terr = 1;
            else if (clearErr) m_terr = 0;
        end
        m_cyc++;
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    // Compare on every falling edge; all outputs are meaningful every cycle.
    initial forever begin
        @(negedge clock);
        chk("cmdReady", cmdReady, int'(mq.size() < DEPTH));
        chk("draw", draw, int'(m_inflight && !m_taken));
        chk("xOrigin", xOrigin, m_x);
        chk("yOrigin", yOrigin, m_y);
        chk("mifId", mifId, m_id);
        chk("busy", busy, int'(m_inflight || mq.size() > 0));
        chk("level", level, mq.size());
        chk("rejected", rejected, m_rej);
        chk("rejectCount", rejectCount, m_rcnt);
        chk("timeoutErr", timeoutErr, m_terr);
    end

    // ------------------------------------------------------------ helpers
    task automatic push_cmd(input int x, input int y, input int id);
        @(negedge clock);
        cmdValid = 1'b1;
        cmdX = 8'(x); cmdY = 9'(y); cmdMifId = 8'(id);
        @(negedge clock);
        cmdValid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clearErr = 1'b1;
        @(negedge clock);
        clearErr = 1'b0;
    endtask

    // One full handshake for a queued command, starting at a falling edge in IDLE.
    task automatic serve_one(input int ex, input int eid, input string tag);
        drawerReady = 1'b1;
        @(negedge clock);
        chk({tag, "_draw"}, draw, 1);
        chk({tag, "_x"}, xOrigin, ex);
        chk({tag, "_id"}, mifId, eid);
        drawerReady = 1'b0;
        @(negedge clock);
        drawerReady = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        int n;
        model_reset();

        // Reset state.
        #3;
        chk("rst_draw", draw, 0);
        chk("rst_level", level, 0);
        chk("rst_cmdReady", cmdReady, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rejectCount", rejectCount, 0);
        chk("rst_timeoutErr", timeoutErr, 0);
        chk("rst_xOrigin", xOrigin, 0);
        @(negedge clock);
        reset = 1'b0;

        // Single command through the full handshake.
        drawerReady = 1'b1;
        push_cmd(10, 20, 3);
        chk("s1_level_after_push", level, 1);
        chk("s1_draw_not_yet", draw, 0);
        @(negedge clock);
        chk("s1_draw", draw, 1);
        chk("s1_x", xOrigin, 10);
        chk("s1_y", yOrigin, 20);
        chk("s1_id", mifId, 3);
        drawerReady = 1'b0;
        @(negedge clock);
        chk("s1_draw_dropped", draw, 0);
        chk("s1_busy_release", busy, 1);
        drawerReady = 1'b1;
        @(negedge clock);
        chk("s1_busy_done", busy, 0);

        // Fill to DEPTH, overflow attempt, drain in order (wraps the pointers).
        drawerReady = 1'b0;
        for (int k = 0; k < DEPTH; k++) push_cmd(k * 20 + 1, k * 30 + 2, k + 40);
        chk("s2_level_full", level, 8);
        chk("s2_cmdReady_full", cmdReady, 0);
        chk("s2_model_full", mq.size(), 8);
        push_cmd(99, 99, 99);
        chk("s2_level_overflow", level, 8);
        chk("s2_no_reject", rejected, 0);
        for (int k = 0; k < DEPTH; k++) serve_one(k * 20 + 1, k + 40, "s2_order");
        chk("s2_drained_busy", busy, 0);
        chk("s2_drained_level", level, 0);

        // Rejections and the on-screen boundary.
        pulse_clear();
        chk("s3_cleared", rejectCount, 0);
        push_cmd(233, 0, 1);
        chk("s3_rej1", rejected, 1);
        chk("s3_cnt1", rejectCount, 1);
        push_cmd(0, 313, 1);
        chk("s3_rej2", rejected, 1);
        chk("s3_cnt2", rejectCount, 2);
        chk("s3_model_cnt", m_rcnt, 2);
        chk("s3_level", level, 0);
        chk("s3_draw", draw, 0);
        @(negedge clock);
        chk("s3_pulse_end", rejected, 0);
        chk("s3_draw_still0", draw, 0);
        push_cmd(232, 312, 7);
        chk("s3_edge_accept", rejected, 0);
        chk("s3_edge_level", level, 1);
        @(negedge clock);
        chk("s3_edge_draw", draw, 1);
        chk("s3_edge_y", yOrigin, 312);
        drawerReady = 1'b0;
        @(negedge clock);
        drawerReady = 1'b1;
        @(negedge clock);

        // Drawer never drops ready: timeout after ACK_TIMEOUT issue cycles.
        push_cmd(5, 6, 7);
        @(negedge clock);
        chk("s4_draw_start", draw, 1);
        n = 1;
        for (int i = 0; i < ACK_TIMEOUT + 80; i++) begin
            @(negedge clock);
            if (!draw) break;
            n++;
        end
        chk("s4_timeout_cycles", n, 1023);
        chk("s4_timeoutErr", timeoutErr, 1);
        chk("s4_model_terr", m_terr, 1);
        chk("s4_busy", busy, 0);
        pulse_clear();
        chk("s4_cleared", timeoutErr, 0);

        // Simultaneous push and pop at level 3.
        drawerReady = 1'b0;
        for (int k = 0; k < 3; k++) push_cmd(100 + k, 200 + k, 10 + k);
        chk("s5_level3", level, 3);
        @(negedge clock);
        drawerReady = 1'b1;
        cmdValid = 1'b1; cmdX = 8'd50; cmdY = 9'd60; cmdMifId = 8'd70;
        @(negedge clock);
        cmdValid = 1'b0;
        chk("s5_level_same", level, 3);
        chk("s5_draw", draw, 1);
        chk("s5_head", xOrigin, 100);
        drawerReady = 1'b0;
        @(negedge clock);
        drawerReady = 1'b1;
        @(negedge clock);
        serve_one(101, 11, "s5_q1");
        serve_one(102, 12, "s5_q2");
        serve_one(50, 70, "s5_q3");
        chk("s5_empty", level, 0);

        // Reset while in RELEASE with 4 entries queued.
        drawerReady = 1'b0;
        for (int k = 0; k < 5; k++) push_cmd(k + 1, k + 1, k + 1);
        @(negedge clock);
        drawerReady = 1'b1;
        @(negedge clock);
        drawerReady = 1'b0;
        @(negedge clock);
        chk("s6_level4", level, 4);
        chk("s6_release_draw", draw, 0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("s6_rst_draw", draw, 0);
        chk("s6_rst_level", level, 0);
        chk("s6_rst_cmdReady", cmdReady, 1);
        chk("s6_rst_busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;

        // Reset while draw is high drops it at once.
        drawerReady = 1'b1;
        push_cmd(9, 9, 9);
        @(negedge clock);
        chk("s6b_draw", draw, 1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("s6b_rst_draw", draw, 0);
        chk("s6b_rst_x", xOrigin, 0);
        @(negedge clock);
        reset = 1'b0;

        // Saturation of the reject counter.
        @(negedge clock);
        cmdValid = 1'b1; cmdX = 8'd250; cmdY = 9'd0;
        repeat (260) @(negedge clock);
        cmdValid = 1'b0;
        chk("s7_saturated", rejectCount, 255);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            cmdValid    = ($urandom_range(0, 99) < 45);
            cmdX        = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(233, 255))
                                                     : 8'($urandom_range(0, 232));
            cmdY        = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(313, 511))
                                                     : 9'($urandom_range(0, 312));
            cmdMifId    = 8'($urandom);
            drawerReady = ($urandom_range(0, 99) < (((i / 400) % 2 == 0) ? 70 : 25));
            clearErr    = ($urandom_range(0, 99) < 3);
        end
        @(negedge clock);
        cmdValid = 1'b0;
        clearErr = 1'b0;
        repeat (3) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
